main_1: RTL and testbench
=========================

# main_1

Parameterised unsigned N×N approximate multiplier (DeBAM style) with a registered 2N-bit product. It is the arithmetic core for low-power datapaths that tolerate small errors in low-order product bits. Partial products are generated from 2-to-4 decoders on bit pairs of B. The lowest M product columns are approximated by OR-compression with no carry, and all higher columns are summed exactly.

## Interface
- N, default 16: operand width; must be even, N ≥ 2.
- M, default 4: number of approximated low product columns; 0 ≤ M ≤ N, where M = 0 gives an exact multiplier.
- clk  input  1: rising-edge clock.
- rst_n  input  1: asynchronous, active-low reset.
- A  input  N: multiplicand, unsigned.
- B  input  N: multiplier, unsigned.
- PRODUCT  output  2N: registered approximate product, unsigned.

## Operation
- Partial-product bit p(i,j) = A[i]·B[j], with column c = i+j.
- Generation:
  - Each B pair (B[2k+1], B[2k]), k = 0…N/2−1, drives a 2-to-4 decoder with one-hot d0..d3.
  - The row-pair contributes 0, A, A<<1 or (A<<1)+A, shifted by 2k.
  - This is functionally equal to the AND array.
- Approximate region, columns c < M:
  - PRODUCT[c] = OR of all p(i,j) with i+j = c.
  - No carry leaves this region.
- Exact region, columns c ≥ M:
  - Sum over all p(i,j)·2^(i+j) with i+j ≥ M, computed exactly with full carry propagation.
  - Taken modulo 2^(2N); it never overflows.
  - Only bits [2N−1:M] of this sum are used; bits below M are zero by construction.
- Result equation: PRODUCT = exact_region_sum + Σ_{c<M} PRODUCT[c]·2^c.
- Error bounds:
  - The result is always ≤ the exact product.
  - The result equals the exact product whenever every column c < M holds at most one set partial product.
- A = 0 or B = 0 yields 0.

## Timing
- Single pipeline stage: PRODUCT is registered on every rising clk edge from the A/B values present at that edge. Latency is 1 cycle and throughput is 1 result per cycle.
- The product computation is purely combinational between the input pins and the output register. Inputs are not registered separately.
- Reset:
  - rst_n low forces PRODUCT = 0 immediately, asynchronously.
  - It holds 0 while rst_n is low.
  - The first valid result appears on the first rising edge after rst_n deasserts.
- Reset mid-operation discards the in-flight result. There is no other state.
- There is no handshake and no enable. A downstream consumer samples PRODUCT one cycle after applying operands.

## Structure
- Shared package:
  - Width helpers (PW = 2N).
  - The decoder select encoding (SEL_ZERO, SEL_A, SEL_2A, SEL_3A).
- Sub-module debam_pp_decoder:
  - Inputs: one B bit pair and A.
  - Outputs: the N+2-bit row-pair partial product and the one-hot decoder lines.
  - Instantiated N/2 times via generate.
- The top level contains:
  - The column-OR logic for c < M.
  - The masked exact adder tree for c ≥ M.
  - The output register.

## Test plan
- Reset and zero operands:
  - Hold rst_n = 0 with arbitrary A/B → PRODUCT = 0 asynchronously.
  - Release rst_n, apply A = 0, B = 0xFFFF → PRODUCT = 0x00000000 after 1 edge.
- Sparse multiplier: A = 0xFFFF, B = 0x8888 → PRODUCT = 0x88877778 (equals exact).
- Dense low bits: A = 0xFFFF, B = 0x89FF → PRODUCT = 0x89FE75DF (exact 0x89FE7601, error −34).
- Max operands: A = 0xFFFF, B = 0xFFFF → PRODUCT = 0xFFFDFFDF (exact 0xFFFE0001, error −34).
- Small values and M = 0:
  - A = 3, B = 3 → PRODUCT = 7 (exact 9).
  - A = 1, B = 1 → 1.
  - Same A = 3, B = 3 with M = 0 → 9.
- Random regression with N = 16, M = 4:
  - 10k random pairs checked against a reference model of the equation above.
  - Also assert PRODUCT ≤ A·B.
  - Assert 1-cycle latency with back-to-back changing inputs every cycle.

Source files
------------

// File: rtl/main_1_pkg.sv
// Shared types and width helpers for the main_1 approximate multiplier.
package main_1_pkg;

    // Default operand width and number of approximated low product columns.
    localparam int unsigned DEF_N = 16;
    localparam int unsigned DEF_M = 4;

    // Select values for the 2-to-4 decoder on each B bit pair.
    typedef enum logic [1:0] {
        SEL_ZERO = 2'd0,
        SEL_A    = 2'd1,
        SEL_2A   = 2'd2,
        SEL_3A   = 2'd3
    } sel_e;

    // Product width (PW) for an n-bit operand.
    function automatic int unsigned pw(input int unsigned n);
        return 2 * n;
    endfunction

endpackage

// File: rtl/main_1_pp_decoder.sv
// Row-pair partial product generator: decodes one B bit pair into a one-hot
// select and emits 0, A, 2A or 3A (N+2 bits, unshifted).
module debam_pp_decoder
    import main_1_pkg::*;
#(
    parameter int unsigned N = DEF_N
) (
    input  logic [1:0]   i_b_pair,
    input  logic [N-1:0] i_a,
    output logic [N+1:0] o_pp,
    output logic [3:0]   o_onehot
);

    sel_e w_sel;

    assign w_sel = sel_e'(i_b_pair);

    // Decode the bit pair and pick the matching multiple of A.
    always_comb begin
        o_onehot = '0;
        o_pp     = '0;
        case (w_sel)
            SEL_ZERO: begin
                o_onehot[0] = 1'b1;
            end
            SEL_A: begin
                o_onehot[1] = 1'b1;
                o_pp        = {2'b00, i_a};
            end
            SEL_2A: begin
                o_onehot[2] = 1'b1;
                o_pp        = {1'b0, i_a, 1'b0};
            end
            SEL_3A: begin
                o_onehot[3] = 1'b1;
                o_pp        = {1'b0, i_a, 1'b0} + {2'b00, i_a};
            end
            default: begin
                o_onehot = '0;
                o_pp     = '0;
            end
        endcase
    end

endmodule

// File: rtl/main_1.sv
// DeBAM-style unsigned NxN approximate multiplier with a registered 2N-bit
// product. Columns below M are OR-compressed without carry; the rest is exact.
module main_1
    import main_1_pkg::*;
#(
    parameter int unsigned N = DEF_N,
    parameter int unsigned M = DEF_M
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N-1:0]      A,
    input  logic [N-1:0]      B,
    output logic [2*N-1:0]    PRODUCT
);

    localparam int unsigned PW = pw(N);
    localparam int unsigned NP = N / 2;

    logic [N+1:0]  w_pp     [NP];
    logic [3:0]    w_onehot [NP];
    logic [N-1:0]  w_b_dec;
    logic [PW-1:0] w_full_sum;
    logic [PW-1:0] w_low_weight;
    logic [PW-1:0] w_low_or;
    logic [PW-1:0] w_result;
    logic [PW-1:0] r_product;

    for (genvar k = 0; k < NP; k++) begin : g_dec
        debam_pp_decoder #(.N(N)) u_dec (
            .i_b_pair (B[2*k+1:2*k]),
            .i_a      (A),
            .o_pp     (w_pp[k]),
            .o_onehot (w_onehot[k])
        );
        // Recover the individual B bits from the one-hot decoder lines.
        assign w_b_dec[2*k]   = w_onehot[k][1] | w_onehot[k][3];
        assign w_b_dec[2*k+1] = ~(w_onehot[k][0] | w_onehot[k][1]);
    end

    // Exact sum of all row-pair partial products, each shifted by 2k.
    always_comb begin
        w_full_sum = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            w_full_sum = w_full_sum + (PW'(w_pp[k]) << (2 * k));
        end
    end

    // Per-column OR and weighted sum of the partial products in columns below M.
    always_comb begin
        w_low_weight = '0;
        w_low_or     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            for (int unsigned j = 0; j < N; j++) begin
                if ((i + j) < M) begin
                    if (A[i] & w_b_dec[j]) begin
                        w_low_weight      = w_low_weight + (PW'(1) << (i + j));
                        w_low_or[i + j]   = 1'b1;
                    end
                end
            end
        end
    end

    // Exact region = full sum minus the low-column terms, which leaves bits
    // below M at zero with every carry from the high columns intact; the
    // OR-compressed low columns then fill those bits.
    always_comb begin
        w_result = (w_full_sum - w_low_weight) + w_low_or;
    end

    // Output register, cleared asynchronously while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_product <= '0;
        end else begin
            r_product <= w_result;
        end
    end

    assign PRODUCT = r_product;

endmodule

// File: tb/tb_main_1.sv
// Scoreboard bench for main_1: a driver pushes expected products, a monitor
// pops and compares one cycle later. Two instances cover M=4 and M=0.
module tb_main_1;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] A     = '0;
    logic [15:0] B     = '0;
    logic [31:0] prod4;
    logic [31:0] prod0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] e4;
        logic [31:0] e0;
        string       name;
    } item_t;

    item_t q[$];
    item_t mon_it;

    main_1 #(.N(16), .M(4)) u_dut4 (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .PRODUCT (prod4)
    );

    main_1 #(.N(16), .M(0)) u_dut0 (
        .clk     (clk),
        .rst_n   (rst_n),
        .A       (A),
        .B       (B),
        .PRODUCT (prod0)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: exact sum of partial products in columns >= m plus OR of columns < m.
    function automatic logic [31:0] ref_model(input logic [15:0] a, input logic [15:0] b,
                                              input int unsigned m);
        logic [31:0] s;
        logic [31:0] orv;
        s   = '0;
        orv = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            for (int unsigned j = 0; j < 16; j++) begin
                if (a[i] && b[j]) begin
                    if (i + j >= m) s = s + (32'd1 << (i + j));
                    else            orv[i + j] = 1'b1;
                end
            end
        end
        return s + orv;
    endfunction

    task automatic push(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] e4, input string name);
        item_t it;
        @(negedge clk);
        A = a;
        B = b;
        it.a    = a;
        it.b    = b;
        it.e4   = e4;
        it.e0   = {16'd0, a} * {16'd0, b};
        it.name = name;
        q.push_back(it);
    endtask

    task automatic drain();
        for (int n = 0; n < 10 && q.size() > 0; n++) @(posedge clk);
    endtask

    // Monitor: one cycle after each edge, compare against the oldest expectation.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            mon_it = q.pop_front();
            check({mon_it.name, "_m4"}, prod4, mon_it.e4);
            check({mon_it.name, "_m0"}, prod0, mon_it.e0);
            checks++;
            if (prod4 > ({16'd0, mon_it.a} * {16'd0, mon_it.b})) begin
                errors++;
                $display("FAIL %s_bound got=%h exceeds exact=%h", mon_it.name, prod4,
                         {16'd0, mon_it.a} * {16'd0, mon_it.b});
            end
        end
    end

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;

        // Reset held with arbitrary operands.
        A = 16'h1234;
        B = 16'h5678;
        repeat (3) @(posedge clk);
        #2;
        check("reset_hold_m4", prod4, 32'h0);
        check("reset_hold_m0", prod0, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors with hand-computed M=4 results.
        push(16'h0000, 16'hFFFF, 32'h00000000, "zero_a");
        push(16'hFFFF, 16'h8888, 32'h88877778, "sparse");
        push(16'hFFFF, 16'h89FF, 32'h89FE75DF, "dense_low");
        push(16'h0003, 16'h0003, 32'h00000007, "three_sq");
        push(16'h0001, 16'h0001, 32'h00000001, "one_sq");
        push(16'h1234, 16'h0000, 32'h00000000, "zero_b");
        push(16'hFFFF, 16'hFFFF, 32'hFFFDFFDF, "max");
        drain();

        // Asynchronous reset between clock edges clears the held product.
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_m4", prod4, 32'h0);
        check("async_reset_m0", prod0, 32'h0);
        A = 16'hFFFF;
        B = 16'hFFFF;
        @(posedge clk);
        #1;
        check("reset_hold2_m4", prod4, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // First result after release, then back-to-back random operands.
        push(16'h00FF, 16'h0101, ref_model(16'h00FF, 16'h0101, 4), "post_reset");
        for (int n = 0; n < 10000; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            push(ra, rb, ref_model(ra, rb, 4), "random");
        end
        drain();

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d expected=0 pending", q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog got=timeout expected=completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

endmodule
